// File: rtl/marquee_scroller.sv
// Stores a valid/ready-written message and scrolls it across DIGITS multiplexed positions; ascii/digit_en registered, 1 clk latency.
// wr_ready drops only for the COMMIT cycle; optional MARQUEE_UCASE_FOLD_EN folds a-z to upper case on write.
module marquee_scroller #(
    parameter int DIGITS     = 4,
    parameter int MSG_DEPTH  = 32,
    parameter int MUX_DIV    = 1024,
    parameter int SCROLL_DIV = 6000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_char,
    input  logic              wr_last,
    output logic [7:0]        ascii,
    output logic [DIGITS-1:0] digit_en
);

    localparam int LW = $clog2(MSG_DEPTH + 1);
    localparam int IW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    localparam int PW = $clog2(2 * (MSG_DEPTH + DIGITS));
    localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [MW-1:0] MUX_TC    = MW'(MUX_DIV - 1);
    localparam logic [SW-1:0] SCROLL_TC = SW'(SCROLL_DIV - 1);
    localparam logic [DW-1:0] DIG_TC    = DW'(DIGITS - 1);
    localparam logic [LW-1:0] FULL_IDX  = LW'(MSG_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic                rdy_q;
    logic [LW-1:0]       wptr_q, wptr_d;
    logic [LW-1:0]       len_q, len_d;
    logic [PW-1:0]       head_q, head_d;
    logic [SW-1:0]       scnt_q, scnt_d;
    logic [MW-1:0]       mcnt_q, mcnt_d;
    logic [DW-1:0]       dig_q, dig_d;
    logic [7:0]          ascii_q, ascii_d;
    logic [DIGITS-1:0]   den_q, den_d;
    logic [7:0]          msg_q [MSG_DEPTH];

    logic                wr_acc;
    logic                mem_we;
    logic [IW-1:0]       mem_idx;
    logic [7:0]          store_char;
    logic [PW-1:0]       vlen;
    logic [PW-1:0]       pos;

    assign wr_ready = rdy_q && (state_q != S_COMMIT);
    assign wr_acc   = wr_valid && wr_ready;
    assign vlen     = PW'(len_q) + PW'(DIGITS);
    assign ascii    = ascii_q;
    assign digit_en = den_q;

`ifdef MARQUEE_UCASE_FOLD_EN
    assign store_char = (wr_char >= 8'h61 && wr_char <= 8'h7A) ? (wr_char - 8'h20) : wr_char;
`else
    assign store_char = wr_char;
`endif

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        len_d   = len_q;
        head_d  = head_q;
        scnt_d  = '0;
        mem_we  = 1'b0;
        mem_idx = IW'(wptr_q);
        case (state_q)
            S_IDLE, S_RUN: begin
                if (state_q == S_RUN) begin
                    scnt_d = (scnt_q == SCROLL_TC) ? '0 : scnt_q + SW'(1);
                    if (scnt_q == SCROLL_TC) begin
                        head_d = (head_q == vlen - PW'(1)) ? '0 : head_q + PW'(1);
                    end
                end
                // A new write always restarts the message, even on a scroll step.
                if (wr_acc) begin
                    mem_we  = 1'b1;
                    mem_idx = '0;
                    wptr_d  = LW'(1);
                    scnt_d  = '0;
                    head_d  = head_q;
                    state_d = (wr_last || MSG_DEPTH == 1) ? S_COMMIT : S_LOAD;
                end
            end
            S_LOAD: begin
                if (wr_acc) begin
                    mem_we = 1'b1;
                    wptr_d = wptr_q + LW'(1);
                    if (wr_last || wptr_q == FULL_IDX) begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                state_d = S_RUN;
                len_d   = wptr_q;
                head_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mcnt_d = (mcnt_q == MUX_TC) ? '0 : mcnt_q + MW'(1);
        dig_d  = dig_q;
        if (mcnt_q == MUX_TC) begin
            dig_d = (dig_q == DIG_TC) ? '0 : dig_q + DW'(1);
        end
    end

    // Window position wraps over message plus DIGITS trailing blanks.
    always_comb begin
        pos = head_q + PW'(dig_q);
        if (pos >= vlen) begin
            pos = pos - vlen;
        end
        ascii_d = 8'h20;
        if (state_q == S_RUN && pos < PW'(len_q)) begin
            ascii_d = msg_q[IW'(pos)];
        end
        den_d        = '0;
        den_d[dig_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            wptr_q  <= '0;
            len_q   <= '0;
            head_q  <= '0;
            scnt_q  <= '0;
            mcnt_q  <= '0;
            dig_q   <= '0;
            ascii_q <= 8'h20;
            den_q   <= DIGITS'(1);
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            wptr_q  <= wptr_d;
            len_q   <= len_d;
            head_q  <= head_d;
            scnt_q  <= scnt_d;
            mcnt_q  <= mcnt_d;
            dig_q   <= dig_d;
            ascii_q <= ascii_d;
            den_q   <= den_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            msg_q[mem_idx] <= store_char;
        end
    end

endmodule

// File: tb/tb_marquee_scroller.sv
// Directed bench for marquee_scroller: reset, scrolling windows, depth limit, reload, case fold, reset mid-load.
module tb_marquee_scroller;

    localparam int DIGITS     = 4;
    localparam int MSG_DEPTH  = 8;
    localparam int MUX_DIV    = 4;
    localparam int SCROLL_DIV = 64;

    typedef struct {
        int          skip;
        logic [31:0] win;
    } win_vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [7:0]        wr_char = 8'h00;
    logic              wr_last = 1'b0;
    logic [7:0]        ascii;
    logic [DIGITS-1:0] digit_en;

    int tests = 0;
    int fails = 0;

    marquee_scroller #(
        .DIGITS    (DIGITS),
        .MSG_DEPTH (MSG_DEPTH),
        .MUX_DIV   (MUX_DIV),
        .SCROLL_DIV(SCROLL_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_char (wr_char),
        .wr_last (wr_last),
        .ascii   (ascii),
        .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Write one character; returns 1 ns after the accepting clock edge.
    task automatic wr(input logic [7:0] c, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_char  = c;
        wr_last  = last;
        while (!wr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            tests++;
            fails++;
            $display("FAIL wr_timeout: wr_ready stayed 0 for char %h", c);
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_rst_ascii"}, ascii, 8'h20);
        chk({tag, "_rst_digit_en"}, digit_en, 4'b0001);
        chk({tag, "_rst_ready"}, wr_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        chk({tag, "_rel_ready_pre"}, wr_ready, 1'b0);
        @(posedge clk);
        #1;
        chk({tag, "_rel_ready_post"}, wr_ready, 1'b1);
    endtask

    // Skip some cycles, then watch 16 cycles and assemble the visible window (digit 0 in the top byte).
    task automatic sample_win(input int skip, output logic [31:0] win);
        logic [7:0] w [4];
        int         cnt [4];
        bit         bad;
        int         idx;
        bad = 1'b0;
        for (int d = 0; d < 4; d++) begin
            w[d]   = 8'h00;
            cnt[d] = 0;
        end
        repeat (skip) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idx = -1;
            for (int d = 0; d < 4; d++) begin
                if (digit_en == (4'b0001 << d)) idx = d;
            end
            if (idx < 0) begin
                bad = 1'b1;
            end else begin
                if (cnt[idx] > 0 && w[idx] !== ascii) bad = 1'b1;
                w[idx] = ascii;
                cnt[idx]++;
            end
        end
        for (int d = 0; d < 4; d++) begin
            if (cnt[d] != MUX_DIV) bad = 1'b1;
        end
        win = bad ? 32'hBADBAD00 : {w[0], w[1], w[2], w[3]};
    endtask

    initial begin
        win_vec_t    hi_tbl [7];
        win_vec_t    depth_tbl [13];
        logic [31:0] win;
        logic [31:0] exp_w;
        logic [7:0]  ch;
        int          idx;

        hi_tbl[0] = '{4,  "HI  "};
        hi_tbl[1] = '{48, "I   "};
        hi_tbl[2] = '{48, "    "};
        hi_tbl[3] = '{48, "   H"};
        hi_tbl[4] = '{48, "  HI"};
        hi_tbl[5] = '{48, " HI "};
        hi_tbl[6] = '{48, "HI  "};

        depth_tbl[0]  = '{4,  "ABCD"};
        depth_tbl[1]  = '{48, "BCDE"};
        depth_tbl[2]  = '{48, "CDEF"};
        depth_tbl[3]  = '{48, "DEFG"};
        depth_tbl[4]  = '{48, "EFGH"};
        depth_tbl[5]  = '{48, "FGH "};
        depth_tbl[6]  = '{48, "GH  "};
        depth_tbl[7]  = '{48, "H   "};
        depth_tbl[8]  = '{48, "    "};
        depth_tbl[9]  = '{48, "   A"};
        depth_tbl[10] = '{48, "  AB"};
        depth_tbl[11] = '{48, " ABC"};
        depth_tbl[12] = '{48, "ABCD"};

        // Reset values and idle blanking
        do_reset("init");
        sample_win(0, win);
        chk("idle_window", win, "    ");

        // "HI": one-cycle commit, first character two cycles after the last write
        wr("H", 1'b0);
        wr("I", 1'b1);
        chk("hi_commit_ready", wr_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("hi_commit_blank", ascii, 8'h20);
        chk("hi_run_ready", wr_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("hi_first_onehot", $onehot(digit_en), 1'b1);
        idx = 0;
        for (int d = 0; d < 4; d++) begin
            if (digit_en == (4'b0001 << d)) idx = d;
        end
        exp_w = "HI  ";
        ch    = exp_w[31-8*idx -: 8];
        chk("hi_first_char", ascii, ch);
        for (int i = 0; i < 7; i++) begin
            sample_win((i == 0) ? hi_tbl[i].skip - 1 : hi_tbl[i].skip, win);
            chk($sformatf("hi_h%0d", i), win, hi_tbl[i].win);
        end

        // Depth limit: eight characters without wr_last commit on the eighth
        for (int i = 0; i < 8; i++) begin
            wr(8'h41 + 8'(i), 1'b0);
        end
        chk("depth_commit_ready", wr_ready, 1'b0);
        for (int i = 0; i < 13; i++) begin
            sample_win(depth_tbl[i].skip, win);
            chk($sformatf("depth_h%0d", i), win, depth_tbl[i].win);
        end

        // Reload during RUN landing on a scroll terminal-count cycle
        wr("H", 1'b0);
        wr("I", 1'b1);
        repeat (63) @(negedge clk);
        wr("X", 1'b1);
        chk("reload_commit_ready", wr_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("reload_commit_blank", ascii, 8'h20);
        chk("reload_run_ready", wr_ready, 1'b1);
        sample_win(3, win);
        chk("reload_h0", win, "X   ");
        sample_win(48, win);
        chk("reload_h1", win, "    ");

        // Case fold
        wr("a", 1'b0);
        wr("b", 1'b1);
        sample_win(4, win);
`ifdef MARQUEE_UCASE_FOLD_EN
        chk("fold_window", win, "AB  ");
`else
        chk("fold_window", win, "ab  ");
`endif

        // Reset in the middle of a load
        wr("A", 1'b0);
        wr("B", 1'b0);
        do_reset("midload");
        wr("Z", 1'b1);
        sample_win(4, win);
        chk("midload_h0", win, "Z   ");
        sample_win(48, win);
        chk("midload_h1", win, "    ");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
